// File: rtl/wb_arbiter_2m_pkg.sv
// Shared constants for the two-master Wishbone arbiter: FSM state codes,
// one-hot grant patterns and the default watchdog timeout.
package wb_arbiter_2m_pkg;

    // Arbiter FSM state encodings
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_GNT0 = 2'd1;
    localparam logic [1:0] ARB_GNT1 = 2'd2;

    // One-hot grant patterns, {m1, m0}
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    // Identity of the master that owned the bus most recently
    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } master_e;

endpackage

// File: rtl/wb_arbiter_2m_wb_watchdog.sv
// Bus watchdog: counts strobe cycles without a slave response and fires a
// single-cycle pulse when the wait reaches TIMEOUT cycles.
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic done,
    output logic fire
);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    // Fire on the TIMEOUT-th unanswered strobe cycle; a response that cycle wins
    always_comb begin
        fire    = stb && !done && (count_q == TO_W'(TIMEOUT - 1));
        count_d = count_q + 1'b1;
        if (!stb || done || fire) begin
            count_d = '0;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter. Round-robin grant held for a whole
// bus cycle, a one-cycle idle bubble between owners, and a watchdog that
// terminates hung transfers with an error to the owning master.
module wb_arbiter_2m
    import wb_arbiter_2m_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned TO_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    // master 0 (data port)
    input  logic [DW-1:0]   m0_data_i,
    output logic [DW-1:0]   m0_data_o,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    // master 1 (instruction port)
    input  logic [DW-1:0]   m1_data_i,
    output logic [DW-1:0]   m1_data_o,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    // slave
    input  logic [DW-1:0]   s_data_i,
    output logic [DW-1:0]   s_data_o,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic [1:0]      gnt_o
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    master_e    last_gnt_q;
    master_e    last_gnt_d;
    logic       wd_fire;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk  (clk),
        .rst  (rst),
        .stb  (s_stb_o),
        .done (s_ack_i | s_err_i),
        .fire (wd_fire)
    );

    // Next grant: ties go to the master that did not own the bus last
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = (last_gnt_q == MST_M1) ? ARB_GNT0 : ARB_GNT1;
                end else if (m0_cyc_i) begin
                    state_d = ARB_GNT0;
                end else if (m1_cyc_i) begin
                    state_d = ARB_GNT1;
                end
            end
            ARB_GNT0: begin
                if (!m0_cyc_i) begin
                    state_d    = ARB_IDLE;
                    last_gnt_d = MST_M0;
                end
            end
            ARB_GNT1: begin
                if (!m1_cyc_i) begin
                    state_d    = ARB_IDLE;
                    last_gnt_d = MST_M1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Grant state and round-robin history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= MST_M1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Bus muxes driven from the registered grant so the slave sees cyc/stb drop at once
    always_comb begin
        s_addr_o  = '0;
        s_data_o  = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        gnt_o     = GNT_NONE;
        case (state_q)
            ARB_GNT0: begin
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                gnt_o    = GNT_M0;
            end
            ARB_GNT1: begin
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                gnt_o    = GNT_M1;
            end
            default: ;
        endcase
    end

    // Responses go only to the granted master; read data is broadcast
    always_comb begin
        m0_ack_o  = s_ack_i & (state_q == ARB_GNT0);
        m1_ack_o  = s_ack_i & (state_q == ARB_GNT1);
        m0_err_o  = (s_err_i | wd_fire) & (state_q == ARB_GNT0);
        m1_err_o  = (s_err_i | wd_fire) & (state_q == ARB_GNT1);
        m0_data_o = s_data_i;
        m1_data_o = s_data_i;
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: vector table, directed corner-case
// sequences and a randomized run against a behavioural reference model.
module tb_wb_arbiter_2m;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   m0_data_i, m0_data_o, m1_data_i, m1_data_o;
    logic [AW-1:0]   m0_addr_i, m1_addr_i, s_addr_o;
    logic [DW/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic            m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic            m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [DW-1:0]   s_data_i, s_data_o;
    logic            s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]      gnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_arbiter_2m #(
        .DW      (DW),
        .AW      (AW),
        .TIMEOUT (TMO),
        .TO_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_data_i (m0_data_i),
        .m0_data_o (m0_data_o),
        .m0_addr_i (m0_addr_i),
        .m0_sel_i  (m0_sel_i),
        .m0_we_i   (m0_we_i),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_data_i (m1_data_i),
        .m1_data_o (m1_data_o),
        .m1_addr_i (m1_addr_i),
        .m1_sel_i  (m1_sel_i),
        .m1_we_i   (m1_we_i),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_data_i  (s_data_i),
        .s_data_o  (s_data_o),
        .s_addr_o  (s_addr_o),
        .s_sel_o   (s_sel_o),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .gnt_o     (gnt_o)
    );

    // {m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb}
    logic [5:0] flags;
    assign flags = {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_stb_o};

    typedef struct packed {
        logic       m0c, m0s, m1c, m1s, ack, err;
        logic [1:0] gnt;
        logic [5:0] flg;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        m0_data_i = '0; m0_addr_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_data_i = '0; m1_addr_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        s_data_i = '0; s_ack_i = 0; s_err_i = 0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        vec_t vecs[11];
        int   t0;
        int   owner, last, wd;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [3:0]    sl0, sl1;
        logic          w0, w1;
        logic          e_stb, e_cyc, e_fire, e_done;
        logic [AW-1:0] e_addr;
        logic [1:0]    e_gnt;
        logic [5:0]    e_flg;

        // ---------------- reset state ----------------
        clear_inputs();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
        #1;
        check("reset_gnt", gnt_o, 2'b00);
        check("reset_flags", flags, 6'b000000);
        check("reset_addr", s_addr_o, '0);
        do_reset();

        // ---------------- vector table: ties and alternation ----------------
        vecs[0]  = '{1, 1, 1, 1, 0, 0, 2'b00, 6'b000000};
        vecs[1]  = '{1, 1, 1, 1, 1, 0, 2'b01, 6'b100011};
        vecs[2]  = '{0, 0, 1, 1, 0, 0, 2'b01, 6'b000000};
        vecs[3]  = '{0, 0, 1, 1, 0, 0, 2'b00, 6'b000000};
        vecs[4]  = '{1, 1, 1, 1, 1, 0, 2'b10, 6'b001011};
        vecs[5]  = '{1, 1, 0, 0, 0, 0, 2'b10, 6'b000000};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 2'b00, 6'b000000};
        vecs[7]  = '{1, 1, 1, 1, 0, 0, 2'b00, 6'b000000};
        vecs[8]  = '{1, 1, 1, 1, 0, 1, 2'b01, 6'b010011};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 2'b01, 6'b000000};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 2'b00, 6'b000000};
        for (int i = 0; i < 11; i++) begin
            m0_cyc_i = vecs[i].m0c; m0_stb_i = vecs[i].m0s;
            m1_cyc_i = vecs[i].m1c; m1_stb_i = vecs[i].m1s;
            s_ack_i  = vecs[i].ack; s_err_i  = vecs[i].err;
            #1;
            check($sformatf("vec%0d_gnt", i), gnt_o, vecs[i].gnt);
            check($sformatf("vec%0d_flags", i), flags, vecs[i].flg);
            step();
        end

        // ---------------- m0 read ----------------
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h3000_0004; m0_sel_i = 4'hf;
        #1; check("rd_gnt_c0", gnt_o, 2'b00);
        step(); #1;
        check("rd_gnt_c1", gnt_o, 2'b01);
        check("rd_addr", s_addr_o, 32'h3000_0004);
        check("rd_noack", m0_ack_o, 0);
        step(); step();
        s_ack_i = 1; s_data_i = 32'hDEAD_BEEF;
        #1;
        check("rd_ack", {m0_ack_o, m1_ack_o}, 2'b10);
        check("rd_data", m0_data_o, 32'hDEAD_BEEF);
        step();
        clear_inputs();
        step(); step();

        // ---------------- grant hold (last owner was m0, so tie goes to m1) ----------------
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h2222_0000;
        m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h1111_0000;
        step();
        s_ack_i = 1;
        for (int b = 0; b < 4; b++) begin
            m1_addr_i = 32'h1111_0000 + 32'(b * 4);
            #1;
            check($sformatf("hold%0d_gnt", b), gnt_o, 2'b10);
            check($sformatf("hold%0d_acks", b), {m0_ack_o, m1_ack_o}, 2'b01);
            check($sformatf("hold%0d_addr", b), s_addr_o, 32'h1111_0000 + 32'(b * 4));
            step();
        end
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        #1; check("hold_release_addr", s_addr_o, m1_addr_i);
        step(); #1; check("hold_bubble", gnt_o, 2'b00);
        step(); #1; check("hold_m0_gnt", gnt_o, 2'b01);
        check("hold_m0_addr", s_addr_o, 32'h2222_0000);
        clear_inputs();
        step();

        // ---------------- watchdog ----------------
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h4000_0000;
        t0 = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (s_stb_o && t0 < 0) t0 = i;
            if (t0 >= 0 && i - t0 < 20) begin
                check($sformatf("wd_err_t%0d", i - t0), m0_err_o,
                      ((i - t0) == TMO - 1) || ((i - t0) == 2 * TMO - 1));
            end
            step();
        end
        if (t0 < 0) check("wd_stb_seen", 0, 1);
        check("wd_gnt_kept", gnt_o, 2'b01);
        clear_inputs();
        step(); step();

        // ---------------- slave error during m1 write, watchdog cleared ----------------
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_addr_i = 32'h5000_0000;
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int i = 0; i < 5; i++) step();
        s_err_i = 1;
        #1; check("serr_errs", {m0_err_o, m1_err_o}, 2'b01);
        check("serr_we", s_we_o, 1);
        step();
        s_err_i = 0;
        for (int i = 1; i <= TMO; i++) begin
            #1;
            check($sformatf("serr_wd%0d", i), {m0_err_o, m1_err_o}, {1'b0, i == TMO});
            step();
        end
        clear_inputs();
        step(); step();

        // ---------------- async reset mid-GNT1 restores round-robin history ----------------
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        m0_cyc_i = 0; m0_stb_i = 0;
        step();
        m1_cyc_i = 1; m1_stb_i = 1;
        step(); #1;
        check("ar_pre_gnt", gnt_o, 2'b10);
        @(posedge clk);
        #2;
        s_ack_i = 1;
        rst = 1'b1;
        #1;
        check("ar_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
        check("ar_gnt", gnt_o, 2'b00);
        check("ar_ack", m1_ack_o, 0);
        step();
        rst = 1'b0;
        s_ack_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1;
        step(); #1;
        check("ar_tie_m0", gnt_o, 2'b01);
        clear_inputs();
        step();

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        owner = -1; last = 1; wd = 0;
        for (int c = 0; c < 600; c++) begin
            if (m0_cyc_i) m0_cyc_i = ($urandom % 5) != 0; else m0_cyc_i = ($urandom % 3) == 0;
            if (m1_cyc_i) m1_cyc_i = ($urandom % 5) != 0; else m1_cyc_i = ($urandom % 3) == 0;
            m0_stb_i = m0_cyc_i && (($urandom % 4) != 0);
            m1_stb_i = m1_cyc_i && (($urandom % 4) != 0);
            m0_addr_i = $urandom; m1_addr_i = $urandom;
            m0_data_i = $urandom; m1_data_i = $urandom;
            m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
            m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
            s_data_i = $urandom;
            s_ack_i = ($urandom % 6) == 0;
            s_err_i = ($urandom % 17) == 0;
            a0 = m0_addr_i; a1 = m1_addr_i; d0 = m0_data_i; d1 = m1_data_i;
            sl0 = m0_sel_i; sl1 = m1_sel_i; w0 = m0_we_i; w1 = m1_we_i;
            #1;
            // model outputs from the current owner
            e_cyc  = (owner == 0) ? m0_cyc_i : (owner == 1) ? m1_cyc_i : 1'b0;
            e_stb  = (owner == 0) ? m0_stb_i : (owner == 1) ? m1_stb_i : 1'b0;
            e_addr = (owner == 0) ? a0 : (owner == 1) ? a1 : '0;
            e_done = s_ack_i || s_err_i;
            e_fire = e_stb && !e_done && (wd == TMO - 1);
            e_gnt  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            e_flg  = {s_ack_i && owner == 0, (s_err_i || e_fire) && owner == 0,
                      s_ack_i && owner == 1, (s_err_i || e_fire) && owner == 1, e_cyc, e_stb};
            check($sformatf("rnd%0d_ctl", c), {gnt_o, flags}, {e_gnt, e_flg});
            check($sformatf("rnd%0d_bus", c), {s_addr_o, s_data_o},
                  {e_addr, (owner == 0) ? d0 : (owner == 1) ? d1 : 32'h0});
            check($sformatf("rnd%0d_misc", c), {s_sel_o, s_we_o, m0_data_o, m1_data_o},
                  {(owner == 0) ? sl0 : (owner == 1) ? sl1 : 4'h0,
                   (owner == 0) ? w0 : (owner == 1) ? w1 : 1'b0, s_data_i, s_data_i});
            // model update
            wd = (!e_stb || e_done || e_fire) ? 0 : wd + 1;
            if (owner < 0) begin
                if (m0_cyc_i && m1_cyc_i) owner = 1 - last;
                else if (m0_cyc_i) owner = 0;
                else if (m1_cyc_i) owner = 1;
            end else if ((owner == 0 && !m0_cyc_i) || (owner == 1 && !m1_cyc_i)) begin
                last  = owner;
                owner = -1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
